// File: rtl/segment_transition_ctrl.sv
// Segment swap controller: latches a segment-change request, commits it on its trigger
// (index wrap, system time, GPIO edge or immediate) and counts loops against a repeat limit.
module segment_transition_ctrl #(
  parameter int NUM_SEGMENT = 2,
  parameter int SEG_W       = (NUM_SEGMENT > 2) ? $clog2(NUM_SEGMENT) : 1,
  parameter int REP_W       = 16,
  parameter int TIME_W      = 64,
  parameter int GPIO_W      = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ_VALID,
  input  logic [SEG_W-1:0]             REQ_SEGMENT,
  input  logic [7:0]                   REQ_MODE,
  input  logic [TIME_W-1:0]            REQ_VALUE,
  input  logic [NUM_SEGMENT*REP_W-1:0] REP,
  input  logic                         IDX_WRAP,
  input  logic [TIME_W-1:0]            SYS_TIME,
  input  logic [GPIO_W-1:0]            GPIO_IN,
  output logic [SEG_W-1:0]             SEGMENT,
  output logic                         SWAP,
  output logic                         STOP,
  output logic                         PENDING,
  output logic                         ERR
);

  localparam int GSEL_W = (GPIO_W > 1) ? $clog2(GPIO_W) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_STOPPED} state_t;
  typedef enum logic [1:0] {M_SYNC_IDX, M_SYS_TIME, M_GPIO, M_IMMEDIATE} mode_t;

  state_t              state_q, state_d;
  mode_t               req_mode_q, req_mode_d;
  logic [SEG_W-1:0]    req_seg_q, req_seg_d;
  logic [TIME_W-1:0]   req_value_q, req_value_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                swap_q, swap_d;
  logic                err_q, err_d;
  logic [REP_W-1:0]    cnt_q, cnt_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic                exh_q, exh_d;
  logic [GPIO_W-1:0]   gpio_dly_q, gpio_dly_d;

  mode_t               in_mode;
  logic                in_mode_ok;
  logic                in_seg_ok;
  logic                accept;
  logic                trig;
  logic                commit;
  logic [GSEL_W-1:0]   gpio_sel;
  logic [GPIO_W-1:0]   gpio_rise;
  logic [REP_W-1:0]    rep_sel;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    in_mode    = M_IMMEDIATE;
    in_mode_ok = 1'b1;
    unique case (REQ_MODE)
      8'h00:   in_mode = M_SYNC_IDX;
      8'h01:   in_mode = M_SYS_TIME;
      8'h02:   in_mode = M_GPIO;
      8'hFF:   in_mode = M_IMMEDIATE;
      default: in_mode_ok = 1'b0;
    endcase
    in_seg_ok = (int'(REQ_SEGMENT) < NUM_SEGMENT);
    accept    = REQ_VALID && in_mode_ok && in_seg_ok;

    gpio_sel  = req_value_q[GSEL_W-1:0];
    gpio_rise = GPIO_IN & ~gpio_dly_q;
    rep_sel   = REP[int'(req_seg_q)*REP_W +: REP_W];

    trig = 1'b0;
    if (state_q == ST_WAIT) begin
      unique case (req_mode_q)
        M_SYNC_IDX:  trig = IDX_WRAP || exh_q;
        M_SYS_TIME:  trig = (SYS_TIME >= req_value_q);
        M_GPIO:      trig = (int'(gpio_sel) < GPIO_W) && gpio_rise[gpio_sel];
        M_IMMEDIATE: trig = 1'b1;
      endcase
    end
    // A fresh request in the trigger cycle supersedes the one that fired.
    commit = trig && !accept;

    state_d     = state_q;
    req_mode_d  = req_mode_q;
    req_seg_d   = req_seg_q;
    req_value_d = req_value_q;
    seg_d       = seg_q;
    swap_d      = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    exh_d       = exh_q;
    gpio_dly_d  = GPIO_IN;

    if (REQ_VALID) err_d = !accept;

    if (accept) begin
      req_mode_d  = in_mode;
      req_seg_d   = REQ_SEGMENT;
      req_value_d = REQ_VALUE;
      state_d     = ST_WAIT;
    end else if (commit) begin
      seg_d   = req_seg_q;
      swap_d  = 1'b1;
      cnt_d   = '0;
      rep_d   = rep_sel;
      exh_d   = 1'b0;
      state_d = ST_RUN;
    end

    // The old segment keeps counting while a request waits; STOP only shows in RUN.
    if (!commit && IDX_WRAP && !exh_q) begin
      cnt_d = cnt_q + 1'b1;
      if ((rep_q != '1) && (cnt_q == rep_q)) begin
        exh_d = 1'b1;
        if (state_d == ST_RUN) state_d = ST_STOPPED;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      req_mode_q  <= M_SYNC_IDX;
      req_seg_q   <= '0;
      req_value_q <= '0;
      seg_q       <= '0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rep_q       <= '1;
      exh_q       <= 1'b0;
      gpio_dly_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_mode_q  <= req_mode_d;
      req_seg_q   <= req_seg_d;
      req_value_q <= req_value_d;
      seg_q       <= seg_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      exh_q       <= exh_d;
      gpio_dly_q  <= gpio_dly_d;
    end
  end

  assign SEGMENT = seg_q;
  assign SWAP    = swap_q;
  assign STOP    = (state_q == ST_STOPPED);
  assign PENDING = (state_q == ST_WAIT);
  assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Scoreboard bench for segment_transition_ctrl: a loop-count reference model predicts the
// outputs after every clock edge; a separate monitor compares them against the DUT.
module tb_segment_transition_ctrl;

  localparam int NSEG = 2;
  localparam int SW   = 2;
  localparam int RW   = 16;
  localparam int TW   = 64;
  localparam int GW   = 4;

  typedef struct packed {
    logic [SW-1:0] seg;
    logic          swap;
    logic          stop;
    logic          pending;
    logic          err;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [SW-1:0]    req_segment;
  logic [7:0]       req_mode;
  logic [TW-1:0]    req_value;
  logic [NSEG*RW-1:0] rep;
  logic             idx_wrap;
  logic [TW-1:0]    sys_time;
  logic [GW-1:0]    gpio_in;
  logic [SW-1:0]    segment;
  logic             swap, stop, pending, err;

  segment_transition_ctrl #(
    .NUM_SEGMENT(NSEG), .SEG_W(SW), .REP_W(RW), .TIME_W(TW), .GPIO_W(GW)
  ) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_SEGMENT(req_segment),
    .REQ_MODE(req_mode), .REQ_VALUE(req_value), .REP(rep), .IDX_WRAP(idx_wrap),
    .SYS_TIME(sys_time), .GPIO_IN(gpio_in), .SEGMENT(segment), .SWAP(swap),
    .STOP(stop), .PENDING(pending), .ERR(err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got seg=%0d swap=%0b stop=%0b pend=%0b err=%0b, want seg=%0d swap=%0b stop=%0b pend=%0b err=%0b",
               name, $time, act.seg, act.swap, act.stop, act.pending, act.err,
               exp.seg, exp.swap, exp.stop, exp.pending, exp.err);
    end
  endtask

  // Reference model: loops played versus the latched limit, plus a pending-request record.
  int          m_seg, m_loops;
  longint      m_limit;            // -1 means infinite
  bit          m_swap, m_err, m_pending, m_exh;
  int          p_seg;
  logic [7:0]  p_mode;
  logic [TW-1:0] p_val;
  logic [GW-1:0] m_gprev;

  task automatic model_reset();
    m_seg = 0; m_loops = 0; m_limit = -1;
    m_swap = 0; m_err = 0; m_pending = 0; m_exh = 0;
    p_seg = 0; p_mode = 8'h00; p_val = '0;
  endtask

  task automatic model_step();
    bit fire, ok, commit;
    int gi;
    logic [RW-1:0] r;
    if (rst) begin
      model_reset();
      m_gprev = '0;
      return;
    end
    fire = 0;
    gi = int'(p_val[1:0]);
    if (m_pending) begin
      case (p_mode)
        8'h00:   fire = idx_wrap || m_exh;
        8'h01:   fire = sys_time >= p_val;
        8'h02:   fire = gpio_in[gi] && !m_gprev[gi];
        default: fire = 1;
      endcase
    end
    ok = req_valid && (int'(req_segment) < NSEG) &&
         (req_mode == 8'h00 || req_mode == 8'h01 || req_mode == 8'h02 || req_mode == 8'hFF);
    commit = fire && !ok;
    m_swap = commit;
    if (req_valid) m_err = !ok;
    if (idx_wrap && !commit && !m_exh) begin
      m_loops++;
      if (m_limit >= 0 && longint'(m_loops) > m_limit) m_exh = 1;
    end
    if (ok) begin
      p_seg = int'(req_segment); p_mode = req_mode; p_val = req_value;
      m_pending = 1;
    end else if (commit) begin
      m_seg = p_seg;
      m_loops = 0;
      r = rep[p_seg*RW +: RW];
      m_limit = (r == {RW{1'b1}}) ? -1 : longint'(r);
      m_exh = 0;
      m_pending = 0;
    end
    m_gprev = gpio_in;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.seg     = SW'(m_seg);
    o.swap    = m_swap;
    o.stop    = m_exh && !m_pending;
    o.pending = m_pending;
    o.err     = m_err;
    return o;
  endfunction

  // One clock: predict the post-edge outputs, queue them, advance to the next falling edge.
  task automatic tick();
    model_step();
    exp_q.push_back(model_obs());
    @(negedge clk);
    req_valid = 1'b0;
    idx_wrap  = 1'b0;
    sys_time  = sys_time + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wrap();
    idx_wrap = 1'b1;
    tick();
  endtask

  task automatic request(input int seg, input logic [7:0] mode, input logic [TW-1:0] val);
    req_valid   = 1'b1;
    req_segment = SW'(seg);
    req_mode    = mode;
    req_value   = val;
    tick();
  endtask

  // Monitor: compares one queued expectation shortly after each rising edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{seg: segment, swap: swap, stop: stop, pending: pending, err: err};
        check("outputs", a, e);
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1; req_valid = 1'b0; req_segment = '0; req_mode = '0; req_value = '0;
    rep = '1; idx_wrap = 1'b0; sys_time = 64'd100; gpio_in = '0;
    model_reset();
    m_gprev = '0;
    idle(2);
    rst = 1'b0;

    // Infinite repeats never stop
    repeat (5) begin wrap(); idle(1); end

    // SYNC_IDX commit on wrap
    request(1, 8'h00, '0);
    idle(2);
    wrap();
    idle(2);

    // Finite repeat count on seg1, then resume seg0 from STOPPED
    rep[RW +: RW] = 16'd2;
    request(1, 8'h00, '0);
    wrap();
    repeat (3) begin idle(1); wrap(); end
    idle(2);
    request(0, 8'h00, '0);
    idle(3);

    // SYS_TIME future and past thresholds
    sys_time = 64'd990;
    request(1, 8'h01, 64'd1000);
    idle(14);
    request(0, 8'h01, 64'd500);
    idle(3);

    // GPIO select 2: edges on other inputs ignored, held-high input does not fire
    gpio_in = '0;
    request(1, 8'h02, 64'd2);
    gpio_in[1] = 1'b1; idle(1);
    gpio_in[1] = 1'b0; idle(2);
    gpio_in[2] = 1'b1; idle(3);
    request(0, 8'h02, 64'd2);
    idle(4);
    gpio_in[2] = 1'b0; idle(1);
    gpio_in[2] = 1'b1; idle(2);

    // Rejected requests, latest-wins replacement, reset during WAIT
    request(2, 8'h00, '0);
    idle(1);
    request(0, 8'h05, '0);
    idle(1);
    request(1, 8'h01, '1);
    request(0, 8'hFF, '0);
    idle(2);
    request(1, 8'h00, '0);
    request(0, 8'h00, '0);
    idle(1);
    wrap();
    idle(1);
    request(1, 8'h00, '0);
    rst = 1'b1; tick();
    rst = 1'b0; idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < NSEG; k++) begin
          r = $urandom_range(0, 4);
          rep[k*RW +: RW] = (r == 4) ? 16'hFFFF : RW'(r);
        end
      end
      if ($urandom_range(0, 11) == 0) begin
        req_valid = 1'b1;
        r = $urandom_range(0, 7);
        req_segment = (r < 7) ? SW'(r % 2) : SW'(2 + $urandom_range(0, 1));
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: req_mode = 8'h00;
          3, 4:    req_mode = 8'h01;
          5, 6:    req_mode = 8'h02;
          7, 8:    req_mode = 8'hFF;
          default: req_mode = 8'($urandom_range(3, 254));
        endcase
        if (req_mode == 8'h01) req_value = sys_time + 64'($urandom_range(0, 30)) - 64'd10;
        else req_value = {32'($urandom), 32'($urandom)};
      end
      idx_wrap = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) gpio_in[$urandom_range(0, GW-1)] ^= 1'b1;
      tick();
    end
    rst = 1'b0;
    idle(2);

    // Drain: every queued expectation must have been consumed
    repeat (10) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
